// File: rtl/bitserial_operand_feeder.sv
// rtl/bitserial_operand_feeder.sv - latches an operand pair, streams the multiplier LSB first
// into a bit-serial multiplier and holds the product (or a timeout error) until it is consumed.

module bitserial_operand_feeder #(
    parameter int MULTIPLICAND_WIDTH = 4,
    parameter int MULTIPLIER_WIDTH   = 4,
    parameter int DONE_TIMEOUT       = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [MULTIPLICAND_WIDTH-1:0]                in_multiplicand,
    input  logic [MULTIPLIER_WIDTH-1:0]                  in_multiplier,
    output logic                                         mul_start,
    output logic [MULTIPLICAND_WIDTH-1:0]                mul_multiplicand,
    output logic                                         mul_serial_bit,
    input  logic                                         mul_done,
    input  logic [MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH-1:0] mul_product,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH-1:0] out_product,
    output logic                                         out_error
);

    localparam int PW  = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH;
    localparam int BCW = $clog2(MULTIPLIER_WIDTH + 1);
    localparam int WCW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_DONE = 2'd2,
        RESULT    = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic                            in_ready_q, in_ready_d;
    logic                            mul_start_q, mul_start_d;
    logic                            mul_serial_bit_q, mul_serial_bit_d;
    logic [MULTIPLICAND_WIDTH-1:0]   mul_multiplicand_q, mul_multiplicand_d;
    logic [MULTIPLIER_WIDTH-1:0]     shreg_q, shreg_d;
    logic [BCW-1:0]                  bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]                  wait_cnt_q, wait_cnt_d;
    logic                            out_valid_q, out_valid_d;
    logic [PW-1:0]                   out_product_q, out_product_d;
    logic                            out_error_q, out_error_d;

    always_comb begin
        state_d            = state_q;
        in_ready_d         = in_ready_q;
        mul_start_d        = 1'b0;
        mul_serial_bit_d   = mul_serial_bit_q;
        mul_multiplicand_d = mul_multiplicand_q;
        shreg_d            = shreg_q;
        bit_cnt_d          = bit_cnt_q;
        wait_cnt_d         = wait_cnt_q;
        out_valid_d        = out_valid_q;
        out_product_d      = out_product_q;
        out_error_d        = out_error_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d            = SHIFT;
                    in_ready_d         = 1'b0;
                    mul_start_d        = 1'b1;
                    mul_serial_bit_d   = in_multiplier[0];
                    mul_multiplicand_d = in_multiplicand;
                    shreg_d            = in_multiplier >> 1;
                    bit_cnt_d          = BCW'(1);
                end
            end
            SHIFT: begin
                // bit_cnt counts multiplier bits already presented, including cycle 1
                if (bit_cnt_q == BCW'(MULTIPLIER_WIDTH)) begin
                    state_d          = WAIT_DONE;
                    mul_serial_bit_d = 1'b0;
                    wait_cnt_d       = '0;
                end else begin
                    mul_serial_bit_d = shreg_q[0];
                    shreg_d          = shreg_q >> 1;
                    bit_cnt_d        = bit_cnt_q + BCW'(1);
                end
            end
            WAIT_DONE: begin
                if (mul_done) begin
                    state_d            = RESULT;
                    out_valid_d        = 1'b1;
                    out_error_d        = 1'b0;
                    out_product_d      = mul_product;
                    mul_multiplicand_d = '0;
                    wait_cnt_d         = '0;
                end else if (wait_cnt_q == WCW'(DONE_TIMEOUT - 1)) begin
                    state_d            = RESULT;
                    out_valid_d        = 1'b1;
                    out_error_d        = 1'b1;
                    out_product_d      = '0;
                    mul_multiplicand_d = '0;
                    wait_cnt_d         = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            RESULT: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    out_error_d = 1'b0;
                    bit_cnt_d   = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            in_ready_q         <= 1'b1;
            mul_start_q        <= 1'b0;
            mul_serial_bit_q   <= 1'b0;
            mul_multiplicand_q <= '0;
            shreg_q            <= '0;
            bit_cnt_q          <= '0;
            wait_cnt_q         <= '0;
            out_valid_q        <= 1'b0;
            out_product_q      <= '0;
            out_error_q        <= 1'b0;
        end else begin
            state_q            <= state_d;
            in_ready_q         <= in_ready_d;
            mul_start_q        <= mul_start_d;
            mul_serial_bit_q   <= mul_serial_bit_d;
            mul_multiplicand_q <= mul_multiplicand_d;
            shreg_q            <= shreg_d;
            bit_cnt_q          <= bit_cnt_d;
            wait_cnt_q         <= wait_cnt_d;
            out_valid_q        <= out_valid_d;
            out_product_q      <= out_product_d;
            out_error_q        <= out_error_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign mul_start        = mul_start_q;
    assign mul_serial_bit   = mul_serial_bit_q;
    assign mul_multiplicand = mul_multiplicand_q;
    assign out_valid        = out_valid_q;
    assign out_product      = out_product_q;
    assign out_error        = out_error_q;

endmodule

// File: tb/tb_bitserial_operand_feeder.sv
// tb/tb_bitserial_operand_feeder.sv - directed scenarios for the bit-serial operand feeder.

module tb_bitserial_operand_feeder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_multiplicand;
    logic [3:0] in_multiplier;
    logic       mul_start;
    logic [3:0] mul_multiplicand;
    logic       mul_serial_bit;
    logic       mul_done;
    logic [7:0] mul_product;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_product;
    logic       out_error;

    int checks = 0;
    int errors = 0;

    bitserial_operand_feeder #(
        .MULTIPLICAND_WIDTH(4),
        .MULTIPLIER_WIDTH  (4),
        .DONE_TIMEOUT      (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_multiplicand (in_multiplicand),
        .in_multiplier   (in_multiplier),
        .mul_start       (mul_start),
        .mul_multiplicand(mul_multiplicand),
        .mul_serial_bit  (mul_serial_bit),
        .mul_done        (mul_done),
        .mul_product     (mul_product),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_product     (out_product),
        .out_error       (out_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Offers (a, b) from IDLE and walks the SHIFT phase; returns in the first WAIT_DONE cycle.
    task automatic feed_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] exp_bits,
                           input bit busy, input bit done_noise);
        in_valid = 1'b1; in_multiplicand = a; in_multiplier = b;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL feed_in_ready_idle: got %b want 1", in_ready);
        end
        tick();
        in_valid = busy;
        if (busy) begin
            in_multiplicand = ~a; in_multiplier = ~b;
        end
        for (int k = 1; k <= 4; k++) begin
            mul_done = done_noise && (k < 4);
            mul_product = 8'hA5;
            checks++;
            if (mul_start !== (k == 1)) begin
                errors++; $display("FAIL shift_start c%0d: got %b want %b", k, mul_start, (k == 1));
            end
            checks++;
            if (mul_serial_bit !== exp_bits[k-1]) begin
                errors++; $display("FAIL shift_bit c%0d: got %b want %b", k, mul_serial_bit, exp_bits[k-1]);
            end
            checks++;
            if (mul_multiplicand !== a) begin
                errors++; $display("FAIL shift_mcand c%0d: got %h want %h", k, mul_multiplicand, a);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL shift_in_ready c%0d: got %b want 0", k, in_ready);
            end
            if (k < 4) tick();
        end
        mul_done = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (mul_serial_bit !== 1'b0 || mul_start !== 1'b0 || mul_multiplicand !== a || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_entry: bit=%b start=%b mcand=%h valid=%b want 0 0 %h 0",
                     mul_serial_bit, mul_start, mul_multiplicand, out_valid, a);
        end
    endtask

    // Idles n_idle WAIT_DONE edges, then pulses mul_done with prod.
    task automatic complete(input int n_idle, input logic [7:0] prod);
        for (int i = 0; i < n_idle; i++) tick();
        mul_done = 1'b1; mul_product = prod;
        tick();
        mul_done = 1'b0; mul_product = 8'h00;
    endtask

    // Checks the held result for hold cycles of backpressure, then handshakes it.
    task automatic drain(input string name, input logic [7:0] prod, input logic err, input int hold);
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_product !== prod || out_error !== err) begin
                errors++;
                $display("FAIL %s_result h%0d: valid=%b prod=%h err=%b want 1 %h %b",
                         name, i, out_valid, out_product, out_error, prod, err);
            end
            if (i < hold) tick();
        end
        checks++;
        if (mul_multiplicand !== 4'h0) begin
            errors++; $display("FAIL %s_mcand_clear: got %h want 0", name, mul_multiplicand);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_error !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_handshake: valid=%b err=%b in_ready=%b want 0 0 1",
                     name, out_valid, out_error, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || mul_start !== 1'b0 || mul_serial_bit !== 1'b0 || mul_multiplicand !== 4'h0 ||
            out_valid !== 1'b0 || out_product !== 8'h00 || out_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b st=%b bit=%b mc=%h v=%b p=%h e=%b want 1 0 0 0 0 00 0",
                     in_ready, mul_start, mul_serial_bit, mul_multiplicand, out_valid, out_product, out_error);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        feed_op(4'h2, 4'h6, 4'b0110, 1'b0, 1'b1);
        complete(2, 8'h0C);
        drain("basic", 8'h0C, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        feed_op(4'hF, 4'hF, 4'b1111, 1'b0, 1'b0);
        complete(0, 8'hE1);
        drain("max", 8'hE1, 1'b0, 0);
        feed_op(4'h3, 4'h5, 4'b0101, 1'b0, 1'b0);
        complete(3, 8'h0F);
        drain("second", 8'h0F, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        feed_op(4'h7, 4'h3, 4'b0011, 1'b0, 1'b0);
        complete(1, 8'h15);
        drain("bp", 8'h15, 1'b0, 5);
    endtask

    task automatic test_timeout();
        feed_op(4'h9, 4'hA, 4'b1010, 1'b0, 1'b0);
        mul_product = 8'hAA;
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_early: valid=%b want 0 after 15 edges", out_valid);
        end
        tick();
        drain("timeout", 8'h00, 1'b1, 0);
        mul_product = 8'h00;
        feed_op(4'h4, 4'h4, 4'b0100, 1'b0, 1'b0);
        complete(15, 8'h10);
        drain("done_at_limit", 8'h10, 1'b0, 0);
    endtask

    task automatic test_busy();
        feed_op(4'h5, 4'h9, 4'b1001, 1'b1, 1'b0);
        complete(0, 8'h2D);
        drain("busy", 8'h2D, 1'b0, 0);
    endtask

    task automatic test_reset_mid_shift();
        int seen_start;
        int seen_valid;
        in_valid = 1'b1; in_multiplicand = 4'hB; in_multiplier = 4'hD;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || mul_start !== 1'b0 || mul_serial_bit !== 1'b0 || mul_multiplicand !== 4'h0 ||
            out_valid !== 1'b0 || out_product !== 8'h00 || out_error !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rdy=%b st=%b bit=%b mc=%h v=%b p=%h e=%b want 1 0 0 0 0 00 0",
                     in_ready, mul_start, mul_serial_bit, mul_multiplicand, out_valid, out_product, out_error);
        end
        tick();
        rst_n = 1'b1;
        seen_start = 0; seen_valid = 0;
        for (int i = 0; i < 25; i++) begin
            mul_done = (i % 3 == 0); mul_product = 8'h8F;
            tick();
            if (mul_start) seen_start++;
            if (out_valid) seen_valid++;
        end
        mul_done = 1'b0; mul_product = 8'h00;
        checks++;
        if (seen_start != 0 || seen_valid != 0) begin
            errors++;
            $display("FAIL abandon_after_reset: starts=%0d valids=%0d want 0 0", seen_start, seen_valid);
        end
        feed_op(4'h3, 4'h5, 4'b0101, 1'b0, 1'b0);
        complete(0, 8'h0F);
        drain("resume", 8'h0F, 1'b0, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_multiplicand = 4'h0; in_multiplier = 4'h0;
        mul_done = 1'b0; mul_product = 8'h00; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_busy();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
